aes_req_arbiter: RTL and testbench

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_rr_arb.sv | 31 +++
 rtl/aes_req_arbiter.sv | 130 +++++++++++++
 tb/tb_aes_req_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES request arbiter
package aes_pkg;

  localparam int AES_BLK_W           = 128;
  localparam int AES_TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_rr_arb.sv
// rtl/aes_rr_arb.sv - two-way round-robin grant with a priority pointer
module aes_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Index that wins when both sides request; flips to the loser after each accept.
  logic prio;

  always_comb begin
    gnt_id = (valid == 2'b11) ? prio : valid[1];
    gnt    = 2'b00;
    if (en) begin
      gnt = (gnt_id ? 2'b10 : 2'b01) & valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~gnt_id;
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - two-requester front end for a shared AES core
// Optional BUSY timeout enabled by defining AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYC = AES_TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                 AES_clk,
  input  logic                 AES_rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_data,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_data,
  input  logic [AES_BLK_W-1:0] req1_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [AES_BLK_W-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 AES_en,
  output logic [AES_BLK_W-1:0] AES_data_in,
  output logic [AES_BLK_W-1:0] AES_key_in,
  input  logic [AES_BLK_W-1:0] AES_data_out,
  input  logic                 AES_data_out_valid
);

  aes_state_e state_q, state_d;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       accept;
  logic       arb_en;
  logic       timeout;

  // Reset is folded in so ready stays low while reset is asserted.
  assign arb_en = (state_q == ST_IDLE) && AES_rst_n;
  assign accept = |gnt;

  aes_rr_arb u_rr_arb (
    .clk    (AES_clk),
    .rst_n  (AES_rst_n),
    .en     (arb_en),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign AES_en     = (state_q == ST_BUSY);
  assign rsp_valid  = (state_q == ST_RESP);

`ifdef AES_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_BUSY) begin
        if (AES_data_out_valid) begin
          rsp_err_q <= 1'b0;
        end else if (timeout) begin
          rsp_err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (AES_data_out_valid || timeout) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      AES_data_in <= '0;
      AES_key_in  <= '0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
    end else begin
      if (accept) begin
        AES_data_in <= gnt_id ? req1_data : req0_data;
        AES_key_in  <= gnt_id ? req1_key  : req0_key;
        rsp_id      <= gnt_id;
      end
      // Core result takes precedence over a same-cycle timeout.
      if (state_q == ST_BUSY) begin
        if (AES_data_out_valid) begin
          rsp_data <= AES_data_out;
        end else if (timeout) begin
          rsp_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - directed self-checking bench for aes_req_arbiter
module tb_aes_req_arbiter;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic         AES_en;
  logic [127:0] AES_data_in, AES_key_in, AES_data_out;
  logic         AES_data_out_valid;

  int checks = 0;
  int errors = 0;
  int core_lat = 0;
  int busy_cnt = 0;
  bit stray = 1'b0;
  int en_n, rdy_n;

  localparam logic [127:0] D0 = 128'h00000049_00000000_00000000_00000000;
  localparam logic [127:0] K0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] D1 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] K1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] D2 = 128'hdeadbeef_00000001_cafef00d_00000002;
  localparam logic [127:0] K2 = 128'h11111111_22222222_33333333_44444444;

  always #5 AES_clk = ~AES_clk;

  aes_req_arbiter #(.TIMEOUT_CYC(8), .CNT_W(8)) dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .req0_valid         (req0_valid),
    .req0_ready         (req0_ready),
    .req0_data          (req0_data),
    .req0_key           (req0_key),
    .req1_valid         (req1_valid),
    .req1_ready         (req1_ready),
    .req1_data          (req1_data),
    .req1_key           (req1_key),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_id             (rsp_id),
    .rsp_data           (rsp_data),
    .rsp_err            (rsp_err),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  // Stand-in for the cipher core: fixed transform, result after core_lat enabled cycles.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    return {d[63:0], d[127:64]} ^ k;
  endfunction

  always @(negedge AES_clk) begin
    if (AES_en) busy_cnt = busy_cnt + 1;
    else        busy_cnt = 0;
    AES_data_out       = core_fn(AES_data_in, AES_key_in);
    AES_data_out_valid = stray || (AES_en && core_lat != 0 && busy_cnt == core_lat);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(output int en_cnt, output int rdy_cnt);
    en_cnt  = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      en_cnt  += int'(AES_en);
      rdy_cnt += int'(req0_ready | req1_ready);
      @(negedge AES_clk);
    end
    check("rsp_seen", rsp_valid, 1'b1);
  endtask

  initial begin
    logic [127:0] dd [2];
    logic [127:0] kk [2];
    logic         exp_id [3];
    dd[0] = D1; kk[0] = K1; dd[1] = D2; kk[1] = K2;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;

    AES_rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge AES_clk);
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_ctl", {rsp_valid, rsp_err, AES_en, rsp_id}, 4'b0000);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_din", AES_data_in, '0);
    check("rst_kin", AES_key_in, '0);
    req0_valid = 1'b0;
    AES_rst_n  = 1'b1;
    @(negedge AES_clk);

    // Single requester 0
    core_lat = 3; req0_data = D0; req0_key = K0; req0_valid = 1'b1; #1;
    check("t1_rdy", {req1_ready, req0_ready}, 2'b01);
    @(negedge AES_clk);
    req0_valid = 1'b0;
    check("t1_en_first", AES_en, 1'b1);
    check("t1_din", AES_data_in, D0);
    check("t1_kin", AES_key_in, K0);
    wait_rsp(en_n, rdy_n);
    check("t1_en_cycles", en_n, 3);
    check("t1_rdy_busy", rdy_n, 0);
    check("t1_id_err_en", {rsp_id, rsp_err, AES_en}, 3'b000);
    check("t1_data", rsp_data, core_fn(D0, K0));
    rsp_ready = 1'b1;
    @(negedge AES_clk);
    check("t1_gap", {AES_en, rsp_valid}, 2'b00);
    rsp_ready = 1'b0;
    @(negedge AES_clk);

    // Requester 1 alone, consumer stalls in RESP
    core_lat = 1; req1_data = D1; req1_key = K1; req1_valid = 1'b1; #1;
    check("t3_rdy", {req1_ready, req0_ready}, 2'b10);
    @(negedge AES_clk);
    req1_valid = 1'b0;
    wait_rsp(en_n, rdy_n);
    check("t3_en_cycles", en_n, 1);
    for (int i = 0; i < 10; i++) begin
      req0_valid = (i >= 2 && i <= 5); #1;
      check("t3_hold_ctl", {rsp_valid, AES_en, req0_ready, req1_ready, rsp_id, rsp_err}, 6'b100010);
      check("t3_hold_data", rsp_data, core_fn(D1, K1));
      @(negedge AES_clk);
    end
    rsp_ready = 1'b1;
    @(negedge AES_clk);
    check("t3_gap", {AES_en, rsp_valid, req0_ready, req1_ready}, 4'b0000);
    rsp_ready = 1'b0;
    @(negedge AES_clk);

    // Reset in the middle of BUSY, then stray core strobes while idle
    core_lat = 0; req0_data = D2; req0_key = K2; req0_valid = 1'b1;
    @(negedge AES_clk);
    req0_valid = 1'b0;
    @(negedge AES_clk);
    check("t5_busy", AES_en, 1'b1);
    AES_rst_n = 1'b0; req1_valid = 1'b1; #1;
    check("t5_rst_ctl", {AES_en, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err}, 6'b000000);
    check("t5_rst_rsp_data", rsp_data, '0);
    check("t5_rst_din", AES_data_in, '0);
    check("t5_rst_kin", AES_key_in, '0);
    repeat (2) @(negedge AES_clk);
    req1_valid = 1'b0;
    AES_rst_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stray = (i == 2 || i == 3);
      @(negedge AES_clk);
      check("t5_idle", {rsp_valid, AES_en}, 2'b00);
    end
    stray = 1'b0;
    check("t5_rsp_data", rsp_data, '0);

    // Both requesters held: grant order 0,1,0 from a fresh pointer
    core_lat = 2; rsp_ready = 1'b1;
    req0_data = D1; req0_key = K1; req1_data = D2; req1_key = K2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      check("t2_gnt", {req1_ready, req0_ready}, exp_id[t] ? 2'b10 : 2'b01);
      @(negedge AES_clk);
      wait_rsp(en_n, rdy_n);
      check("t2_en_cycles", en_n, 2);
      check("t2_id", rsp_id, exp_id[t]);
      check("t2_data", rsp_data, core_fn(dd[exp_id[t]], kk[exp_id[t]]));
      @(negedge AES_clk);
      check("t2_gap", {AES_en, rsp_valid, req0_ready, req1_ready}, 4'b0000);
      if (t == 2) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge AES_clk);
    end
    rsp_ready = 1'b0;

`ifdef AES_ARB_TIMEOUT_EN
    // Core never answers: error response after 8 BUSY cycles
    core_lat = 0; req0_data = D0; req0_key = K0; req0_valid = 1'b1;
    @(negedge AES_clk);
    req0_valid = 1'b0;
    wait_rsp(en_n, rdy_n);
    check("t4_to_cycles", en_n, 8);
    check("t4_to_err", rsp_err, 1'b1);
    check("t4_to_data", rsp_data, '0);
    rsp_ready = 1'b1;
    repeat (2) @(negedge AES_clk);
    rsp_ready = 1'b0;
    // Core answers on the last allowed cycle: result wins
    core_lat = 8; req0_valid = 1'b1;
    @(negedge AES_clk);
    req0_valid = 1'b0;
    wait_rsp(en_n, rdy_n);
    check("t4_edge_cycles", en_n, 8);
    check("t4_edge_err", rsp_err, 1'b0);
    check("t4_edge_data", rsp_data, core_fn(D0, K0));
    rsp_ready = 1'b1;
    repeat (2) @(negedge AES_clk);
    rsp_ready = 1'b0;
`else
    // Without the timeout, BUSY waits for the core indefinitely
    core_lat = 0; req0_data = D0; req0_key = K0; req0_valid = 1'b1;
    @(negedge AES_clk);
    req0_valid = 1'b0;
    repeat (30) @(negedge AES_clk);
    check("t4_wait", {AES_en, rsp_valid, rsp_err}, 3'b100);
    AES_rst_n = 1'b0;
    @(negedge AES_clk);
    AES_rst_n = 1'b1;
    @(negedge AES_clk);
    check("t4_after_rst", {AES_en, rsp_valid}, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
